// File: rtl/currctrl_reg_scanner.sv
// Port-2 scanner for the current-control register RAM: burst-reads setpoints, commits them atomically, writes status back.
// Define CURRCTRL_SCAN_SEQCNT_EN to append a scan-sequence counter word after the status block.
module currctrl_reg_scanner #(
  parameter int         NUM_SP  = 4,
  parameter int         NUM_ST  = 2,
  parameter logic [7:0] SP_BASE = 8'h00,
  parameter logic [7:0] ST_BASE = 8'h80
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  output logic [7:0]            ram_address,
  output logic                  ram_chipselect,
  output logic                  ram_write,
  output logic [3:0]            ram_byteenable,
  output logic [31:0]           ram_writedata,
  input  logic [31:0]           ram_readdata,
  input  logic [32*NUM_ST-1:0]  status_in,
  output logic [32*NUM_SP-1:0]  sp_data,
  output logic                  sp_valid,
  output logic                  busy,
  output logic [7:0]            overrun_cnt
);

`ifdef CURRCTRL_SCAN_SEQCNT_EN
  typedef enum logic [2:0] {S_IDLE, S_READ, S_RD_LAST, S_COMMIT, S_WRITE, S_SEQ} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_READ, S_RD_LAST, S_COMMIT, S_WRITE} state_t;
`endif

  localparam logic [3:0] SP_LAST = 4'(NUM_SP - 1);
  localparam logic [3:0] ST_LAST = 4'(NUM_ST - 1);

  state_t               state_q;
  logic [3:0]           rd_idx_q;
  logic [3:0]           wr_idx_q;
  logic [7:0]           addr_q;
  logic                 cs_q;
  logic                 we_q;
  logic [31:0]          wdata_q;
  logic [32*NUM_ST-1:0] st_shadow_q;
  logic [32*NUM_SP-1:0] sp_data_q;
  logic                 sp_valid_q;
  logic                 busy_q;
  logic [7:0]           ovr_q;
  logic [32*NUM_SP-1:0] sp_shadow_flat;
  logic [3:0]           wr_sel_d;
  logic [31:0]          st_word_d;
`ifdef CURRCTRL_SCAN_SEQCNT_EN
  logic [31:0]          seq_cnt_q;
`endif

  // Read data for the address issued last cycle lands in shadow word r-1; RD_LAST catches the final word.
  for (genvar gi = 0; gi < NUM_SP; gi++) begin : g_shadow
    localparam bit IS_LAST = (gi == NUM_SP - 1);
    logic [31:0] word_q;
    logic        cap;
    assign cap = (state_q == S_READ && {1'b0, rd_idx_q} == 5'(gi + 1)) ||
                 (state_q == S_RD_LAST && IS_LAST);
    always_ff @(posedge clk or posedge reset) begin
      if (reset)    word_q <= '0;
      else if (cap) word_q <= ram_readdata;
    end
    assign sp_shadow_flat[32*gi +: 32] = word_q;
  end

  always_comb begin
    wr_sel_d  = (state_q == S_WRITE) ? wr_idx_q + 4'd1 : 4'd0;
    st_word_d = '0;
    for (int k = 0; k < NUM_ST; k++)
      if (wr_sel_d == 4'(k)) st_word_d = st_shadow_q[32*k +: 32];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rd_idx_q    <= '0;
      wr_idx_q    <= '0;
      addr_q      <= '0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      st_shadow_q <= '0;
      sp_data_q   <= '0;
      sp_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      ovr_q       <= '0;
`ifdef CURRCTRL_SCAN_SEQCNT_EN
      seq_cnt_q   <= '0;
`endif
    end else begin
      sp_valid_q <= 1'b0;
      if (tick && state_q != S_IDLE && ovr_q != 8'hFF) ovr_q <= ovr_q + 8'd1;
      case (state_q)
        S_IDLE: if (tick) begin
          state_q     <= S_READ;
          busy_q      <= 1'b1;
          st_shadow_q <= status_in;
          rd_idx_q    <= '0;
          wr_idx_q    <= '0;
          addr_q      <= SP_BASE;
          cs_q        <= 1'b1;
        end
        S_READ: begin
          if (rd_idx_q == SP_LAST) begin
            state_q <= S_RD_LAST;
            addr_q  <= '0;
            cs_q    <= 1'b0;
          end else begin
            rd_idx_q <= rd_idx_q + 4'd1;
            addr_q   <= SP_BASE + 8'(rd_idx_q) + 8'd1;
          end
        end
        S_RD_LAST: state_q <= S_COMMIT;
        S_COMMIT: begin
          state_q    <= S_WRITE;
          sp_data_q  <= sp_shadow_flat;
          sp_valid_q <= 1'b1;
          addr_q     <= ST_BASE;
          cs_q       <= 1'b1;
          we_q       <= 1'b1;
          wdata_q    <= st_word_d;
        end
        S_WRITE: begin
          if (wr_idx_q == ST_LAST) begin
`ifdef CURRCTRL_SCAN_SEQCNT_EN
            state_q <= S_SEQ;
            addr_q  <= ST_BASE + 8'(NUM_ST);
            wdata_q <= seq_cnt_q;
`else
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
`endif
          end else begin
            wr_idx_q <= wr_idx_q + 4'd1;
            addr_q   <= ST_BASE + 8'(wr_idx_q) + 8'd1;
            wdata_q  <= st_word_d;
          end
        end
`ifdef CURRCTRL_SCAN_SEQCNT_EN
        S_SEQ: begin
          seq_cnt_q <= seq_cnt_q + 32'd1;
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          addr_q    <= '0;
          cs_q      <= 1'b0;
          we_q      <= 1'b0;
          wdata_q   <= '0;
        end
`endif
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          addr_q  <= '0;
          cs_q    <= 1'b0;
          we_q    <= 1'b0;
          wdata_q <= '0;
        end
      endcase
    end
  end

  assign ram_address    = addr_q;
  assign ram_chipselect = cs_q;
  assign ram_write      = we_q;
  assign ram_byteenable = {4{cs_q}};
  assign ram_writedata  = wdata_q;
  assign sp_data        = sp_data_q;
  assign sp_valid       = sp_valid_q;
  assign busy           = busy_q;
  assign overrun_cnt    = ovr_q;

endmodule

// File: tb/tb_currctrl_reg_scanner.sv
// Bench for currctrl_reg_scanner: behavioural RAM on port 2, random setpoint/status scans, overrun, reset and wrap checks.
module tb_currctrl_reg_scanner;
  localparam int         NUM_SP  = 4;
  localparam int         NUM_ST  = 2;
  localparam logic [7:0] SP_BASE = 8'hFE;
  localparam logic [7:0] ST_BASE = 8'h80;
`ifdef CURRCTRL_SCAN_SEQCNT_EN
  localparam int SEQ_W = 1;
`else
  localparam int SEQ_W = 0;
`endif
  localparam int          BUSY_CYC = NUM_SP + NUM_ST + 2 + SEQ_W;
  localparam int          VALID_AT = NUM_SP + 2;
  localparam logic [31:0] SENTINEL = 32'h5EC0_A55A;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 tick = 1'b0;
  logic [7:0]           ram_address;
  logic                 ram_chipselect;
  logic                 ram_write;
  logic [3:0]           ram_byteenable;
  logic [31:0]          ram_writedata;
  logic [31:0]          ram_readdata;
  logic [32*NUM_ST-1:0] status_in;
  logic [32*NUM_SP-1:0] sp_data;
  logic                 sp_valid;
  logic                 busy;
  logic [7:0]           overrun_cnt;

  int n_vec = 0;
  int n_err = 0;

  currctrl_reg_scanner #(
    .NUM_SP(NUM_SP), .NUM_ST(NUM_ST), .SP_BASE(SP_BASE), .ST_BASE(ST_BASE)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_byteenable(ram_byteenable), .ram_writedata(ram_writedata), .ram_readdata(ram_readdata),
    .status_in(status_in), .sp_data(sp_data), .sp_valid(sp_valid), .busy(busy),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  // Register RAM: port 1 is the CPU side, port 2 has a registered address.
  logic [31:0] mem [256];
  logic [7:0]  addr_reg = 8'h00;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_addr = 8'h00;
  logic [31:0] cpu_data = 32'h0;
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [7:0]  addr;
    logic [31:0] data;
  } acc_t;
  acc_t acc_log [$];

  assign ram_readdata = mem[addr_reg];

  always @(posedge clk) begin
    if (cpu_we) mem[cpu_addr] <= cpu_data;
    if (ram_chipselect) begin
      addr_reg <= ram_address;
      if (ram_write)
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      acc_log.push_back({ram_write, ram_byteenable, ram_address, ram_writedata});
    end
  end

  logic [32*NUM_SP-1:0] exp_sp;
  logic [7:0]           exp_ovr;
  logic [31:0]          exp_seq;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d);
    cpu_addr = a;
    cpu_data = d;
    cpu_we   = 1'b1;
    @(posedge clk); #1;
    cpu_we   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".addr"},  256'(ram_address), 256'(0));
    check({tag, ".cs"},    256'(ram_chipselect), 256'(0));
    check({tag, ".we"},    256'(ram_write), 256'(0));
    check({tag, ".be"},    256'(ram_byteenable), 256'(0));
    check({tag, ".wdata"}, 256'(ram_writedata), 256'(0));
    check({tag, ".sp"},    256'(sp_data), 256'(0));
    check({tag, ".valid"}, 256'(sp_valid), 256'(0));
    check({tag, ".busy"},  256'(busy), 256'(0));
    check({tag, ".ovr"},   256'(overrun_cnt), 256'(0));
  endtask

  // One full scan with fresh random setpoints and status; optionally fires three ticks while busy.
  task automatic run_scan(input bit inject);
    logic [32*NUM_SP-1:0] new_sp;
    logic [32*NUM_ST-1:0] snap;
    acc_t                 exp_q [$];
    logic [7:0]           a;
    for (int i = 0; i < NUM_SP; i++) begin
      new_sp[32*i +: 32] = $urandom;
      a = SP_BASE + 8'(i);
      cpu_write(a, new_sp[32*i +: 32]);
      exp_q.push_back({1'b0, 4'hF, a, 32'h0});
    end
    for (int j = 0; j < NUM_ST; j++) begin
      snap[32*j +: 32] = $urandom;
      exp_q.push_back({1'b1, 4'hF, ST_BASE + 8'(j), snap[32*j +: 32]});
    end
    if (SEQ_W != 0) exp_q.push_back({1'b1, 4'hF, ST_BASE + 8'(NUM_ST), exp_seq});
    status_in = snap;
    acc_log.delete();
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    for (int k = 0; k <= BUSY_CYC; k++) begin
      if (k == 1) status_in = ~snap;
      tick = inject && (k == 2 || k == 4 || k == 6);
      check("busy", 256'(busy), 256'(k < BUSY_CYC));
      check("sp_valid", 256'(sp_valid), 256'(k == VALID_AT));
      check("sp_data", 256'(sp_data), 256'((k >= VALID_AT) ? new_sp : exp_sp));
      @(posedge clk); #1;
    end
    tick = 1'b0;
    exp_sp = new_sp;
    if (inject) exp_ovr = (exp_ovr > 8'd252) ? 8'hFF : exp_ovr + 8'd3;
    check("overrun_cnt", 256'(overrun_cnt), 256'(exp_ovr));
    check("access_count", 256'(acc_log.size()), 256'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < acc_log.size(); i++) begin
      if (exp_q[i].we)
        check($sformatf("access%0d", i), 256'(acc_log[i]), 256'(exp_q[i]));
      else
        check($sformatf("access%0d", i), 256'({acc_log[i].we, acc_log[i].be, acc_log[i].addr}),
              256'({exp_q[i].we, exp_q[i].be, exp_q[i].addr}));
    end
    for (int j = 0; j < NUM_ST; j++)
      check($sformatf("status_ram%0d", j), 256'(mem[ST_BASE + 8'(j)]), 256'(snap[32*j +: 32]));
    check("seq_word", 256'(mem[ST_BASE + 8'(NUM_ST)]), 256'((SEQ_W != 0) ? exp_seq : SENTINEL));
    if (SEQ_W != 0) exp_seq = exp_seq + 32'd1;
  endtask

  initial begin
    status_in = '0;
    exp_sp    = '0;
    exp_ovr   = 8'h00;
    exp_seq   = 32'h0;
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    cpu_write(ST_BASE + 8'(NUM_ST), SENTINEL);

    for (int s = 0; s < 4; s++) run_scan(1'b0);
    run_scan(1'b1);
    run_scan(1'b0);

    // Reset during the third cycle of a scan.
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    acc_log.delete();
    check_all_zero("midreset");
    @(posedge clk); #1;
    reset   = 1'b0;
    exp_sp  = '0;
    exp_ovr = 8'h00;
    exp_seq = 32'h0;
    repeat (3) begin @(posedge clk); #1; end
    check("post_reset_access", 256'(acc_log.size()), 256'(0));
    run_scan(1'b0);
    run_scan(1'b0);

    // Tick held high: at most one tick in every BUSY_CYC+1 is accepted, the rest are dropped.
    tick = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    tick = 1'b0;
    check("ovr_saturate", 256'(overrun_cnt), 256'(8'hFF));
    for (int t = 0; t < BUSY_CYC + 2 && busy; t++) begin
      @(posedge clk); #1;
    end
    check("drain_busy", 256'(busy), 256'(0));
    check("ovr_hold", 256'(overrun_cnt), 256'(8'hFF));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
